// File: rtl/mem_write_buffer.sv
// Posted-store buffer between the MEM stage and the cache controller.
// Stores queue in a small FIFO and drain one at a time; loads forward from it or miss to the cache.
module mem_write_buffer #(
  parameter int DEPTH    = 4,
  parameter int ADDR_LEN = 18,
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_LEN-1:0] addr,
  input  logic [DATA_LEN-1:0] data_in,
  input  logic                MEM_R_en,
  input  logic                MEM_W_en,
  output logic [DATA_LEN-1:0] data_out,
  output logic                freeze,
  output logic [ADDR_LEN-1:0] cache_addr,
  output logic [DATA_LEN-1:0] cache_data_in,
  output logic                cache_R_en,
  output logic                cache_W_en,
  input  logic [DATA_LEN-1:0] cache_data_out,
  input  logic                cache_freeze
);

  // state | meaning
  // IDLE  | no cache access in flight
  // WR    | draining the head entry to the cache
  // RD    | cache read for a load that missed the buffer
  typedef enum logic [1:0] {IDLE, WR, RD} state_t;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  state_t              state;
  logic [ADDR_LEN-1:0] ent_addr [DEPTH];
  logic [DATA_LEN-1:0] ent_data [DEPTH];
  logic [DEPTH-1:0]    ent_valid;
  logic [PTR_W-1:0]    head;
  logic [PTR_W-1:0]    tail;
  logic [CNT_W-1:0]    count;

  logic                is_load;
  logic                is_store;
  logic                full;
  logic                hit;
  logic [DATA_LEN-1:0] hit_data;
  logic [PTR_W-1:0]    idx;
  logic                load_miss;
  logic                wr_done;
  logic                rd_done;
  logic                enq;
  logic                deq;

  assign is_load   = MEM_R_en;
  assign is_store  = MEM_W_en & ~MEM_R_en;
  assign full      = (count == FULL_CNT);
  assign load_miss = is_load & ~hit;
  assign wr_done   = (state == WR) & ~cache_freeze;
  assign rd_done   = (state == RD) & ~cache_freeze;
  assign enq       = is_store & ~full;
  assign deq       = wr_done;

  // Walk oldest to youngest so the last match wins; the draining head is still valid here.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (ent_valid[idx] && (ent_addr[idx][ADDR_LEN-1:2] == addr[ADDR_LEN-1:2])) begin
        hit      = 1'b1;
        hit_data = ent_data[idx];
      end
    end
  end

  always_comb begin
    data_out = '0;
    if (is_load) begin
      if (hit)
        data_out = hit_data;
      else if (rd_done)
        data_out = cache_data_out;
    end
  end

  assign freeze        = (is_store & full) | (load_miss & ~rd_done);
  assign cache_addr    = (state == RD) ? addr : ent_addr[head];
  assign cache_data_in = ent_data[head];

  always_ff @(posedge clk) begin
    if (enq) begin
      ent_addr[tail] <= addr;
      ent_data[tail] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      ent_valid  <= '0;
      cache_R_en <= 1'b0;
      cache_W_en <= 1'b0;
    end else begin
      if (deq) begin
        ent_valid[head] <= 1'b0;
        head            <= head + PTR_W'(1);
      end
      if (enq) begin
        ent_valid[tail] <= 1'b1;
        tail            <= tail + PTR_W'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      case (state)
        IDLE: begin
          if (load_miss) begin
            state      <= RD;
            cache_R_en <= 1'b1;
          end else if (count != '0) begin
            state      <= WR;
            cache_W_en <= 1'b1;
          end
        end
        WR: begin
          if (!cache_freeze) begin
            if (load_miss) begin
              state      <= RD;
              cache_W_en <= 1'b0;
              cache_R_en <= 1'b1;
            end else if (count > CNT_W'(1)) begin
              state <= WR;
            end else begin
              state      <= IDLE;
              cache_W_en <= 1'b0;
            end
          end
        end
        RD: begin
          if (!cache_freeze) begin
            state      <= IDLE;
            cache_R_en <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          cache_R_en <= 1'b0;
          cache_W_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_write_buffer.sv
// Scoreboarded bench for mem_write_buffer: program-order memory model against a modelled cache.
module tb_mem_write_buffer;
  localparam int AL = 18;
  localparam int DL = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AL-1:0] addr;
  logic [DL-1:0] data_in;
  logic          MEM_R_en, MEM_W_en;
  logic [DL-1:0] data_out;
  logic          freeze;
  logic [AL-1:0] cache_addr;
  logic [DL-1:0] cache_data_in;
  logic          cache_R_en, cache_W_en;
  logic [DL-1:0] cache_data_out;
  logic          cache_freeze;

  mem_write_buffer #(.DEPTH(4), .ADDR_LEN(AL), .DATA_LEN(DL)) dut (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in),
    .MEM_R_en(MEM_R_en), .MEM_W_en(MEM_W_en), .data_out(data_out), .freeze(freeze),
    .cache_addr(cache_addr), .cache_data_in(cache_data_in),
    .cache_R_en(cache_R_en), .cache_W_en(cache_W_en),
    .cache_data_out(cache_data_out), .cache_freeze(cache_freeze)
  );

  always #5 clk = ~clk;

  // cache model (written by monitor) and architectural memory (written by stimulus)
  logic [DL-1:0]    cmem [64];
  bit               cw   [64];
  logic [DL-1:0]    arch [64];
  bit               aw   [64];
  logic [AL+DL-1:0] wq [$];
  logic [DL-1:0]    lq [$];
  int total = 0, bad = 0;
  int wr_seen = 0, rd_seen = 0, rdcyc = 0, wr_at_rd = 0;
  bit cf_random = 1'b0;
  logic [5:0]       ci;
  logic [AL+DL-1:0] exp_wr;
  logic [DL-1:0]    exp_ld;

  function automatic logic [DL-1:0] init_val(input logic [5:0] i);
    return 32'hC0DE_0000 | {26'b0, i};
  endfunction

  always_comb begin
    ci = cache_addr[7:2];
    cache_data_out = cw[ci] ? cmem[ci] : init_val(ci);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (cf_random) cache_freeze = ($urandom_range(0, 2) == 0);
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (cache_W_en && !cache_freeze) begin
        if (wq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: actual=%0h required=none", cache_addr);
        end else begin
          exp_wr = wq.pop_front();
          chk("cache_write", 64'({cache_addr, cache_data_in}), 64'(exp_wr));
          cmem[cache_addr[7:2]] = cache_data_in;
          cw[cache_addr[7:2]] = 1'b1;
          wr_seen++;
        end
      end
      if (cache_R_en) begin
        rdcyc++;
        chk("read_addr", 64'(cache_addr), 64'(addr));
        if (!cache_freeze) begin
          rd_seen++;
          wr_at_rd = wr_seen;
        end
      end
      if (MEM_R_en && !freeze) begin
        if (lq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_load: actual=%0h required=none", data_out);
        end else begin
          exp_ld = lq.pop_front();
          chk("load_data", 64'(data_out), 64'(exp_ld));
        end
      end
      if (!MEM_R_en) chk("data_out_idle", 64'(data_out), 64'(0));
    end
  end

  // kind: 0 idle, 1 store, 2 load, 3 load+store enables together
  task automatic do_op(input int kind, input logic [AL-1:0] a, input logic [DL-1:0] d,
                       output int stalls);
    addr = a; data_in = d;
    MEM_W_en = (kind == 1 || kind == 3);
    MEM_R_en = (kind == 2 || kind == 3);
    if (kind == 1) begin
      wq.push_back({a, d});
      arch[a[7:2]] = d;
      aw[a[7:2]] = 1'b1;
    end else if (kind >= 2) begin
      lq.push_back(aw[a[7:2]] ? arch[a[7:2]] : init_val(a[7:2]));
    end
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!freeze) break;
      stalls++;
      if (stalls > 300) begin
        total++; bad++;
        $display("FAIL op_timeout: actual=%0d stalls required=<300", stalls);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    MEM_W_en = 1'b0; MEM_R_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int k = 0;
    while (wq.size() != 0 && k < 1000) begin @(posedge clk); #1; k++; end
    chk("drain_empty", 64'(wq.size()), 64'(0));
    idle(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s, s5, w0, r0, rc0, kind, r;
    logic [AL-1:0] a;
    rst = 1'b1; addr = '0; data_in = '0; MEM_R_en = 1'b0; MEM_W_en = 1'b0;
    cache_freeze = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_freeze", 64'(freeze), 64'(0));
    chk("rst_wen", 64'(cache_W_en), 64'(0));
    chk("rst_ren", 64'(cache_R_en), 64'(0));
    chk("rst_dout", 64'(data_out), 64'(0));
    @(posedge clk); #1;

    // back-to-back stores drain in order with no stall
    w0 = wr_seen;
    do_op(1, 18'h10, 32'hAAAA_0001, s); chk("t1_stall_a", 64'(s), 64'(0));
    do_op(1, 18'h14, 32'hBBBB_0002, s); chk("t1_stall_b", 64'(s), 64'(0));
    do_op(1, 18'h10, 32'hCCCC_0003, s); chk("t1_stall_c", 64'(s), 64'(0));
    drain();
    chk("t1_writes", 64'(wr_seen - w0), 64'(3));

    // youngest match forwarded while the cache is stuck
    cache_freeze = 1'b1;
    rc0 = rdcyc;
    do_op(1, 18'h10, 32'hAAAA_1111, s);
    do_op(1, 18'h10, 32'hCCCC_2222, s);
    do_op(2, 18'h10, 32'h0, s);
    chk("t2_fwd_stall", 64'(s), 64'(0));
    idle(2);
    chk("t2_no_read", 64'(rdcyc - rc0), 64'(0));
    cache_freeze = 1'b0;
    drain();

    // fifth store waits for the first drain, then is accepted the next cycle
    cache_freeze = 1'b1;
    w0 = wr_seen;
    for (int i = 0; i < 4; i++) begin
      do_op(1, 18'h60 + 18'(4 * i), 32'h5000_0000 + 32'(i), s);
      chk("t3_stall_first4", 64'(s), 64'(0));
    end
    fork
      do_op(1, 18'h70, 32'h5000_0004, s5);
      begin repeat (3) @(posedge clk); #1; cache_freeze = 1'b0; end
    join
    chk("t3_stall_fifth", 64'(s5), 64'(4));
    drain();
    chk("t3_writes", 64'(wr_seen - w0), 64'(5));

    // load miss behind an in-flight drain
    cache_freeze = 1'b1;
    w0 = wr_seen; r0 = rd_seen;
    do_op(1, 18'h30, 32'hDDDD_0004, s);
    idle(1);
    fork
      do_op(2, 18'h40, 32'h0, s);
      begin repeat (2) @(posedge clk); #1; cache_freeze = 1'b0; end
    join
    chk("t4_miss_stall", 64'(s), 64'(3));
    chk("t4_write_before_read", 64'(wr_at_rd - w0), 64'(1));
    chk("t4_reads", 64'(rd_seen - r0), 64'(1));
    drain();

    // reset mid-drain discards buffered stores
    cache_freeze = 1'b1;
    do_op(1, 18'h50, 32'hE000_0001, s);
    do_op(1, 18'h54, 32'hE000_0002, s);
    do_op(1, 18'h58, 32'hE000_0003, s);
    idle(1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wq.delete();
    for (int i = 0; i < 64; i++) begin
      arch[i] = cw[i] ? cmem[i] : init_val(6'(i));
      aw[i] = 1'b1;
    end
    @(negedge clk);
    chk("t5_wen_after_rst", 64'(cache_W_en), 64'(0));
    chk("t5_freeze_after_rst", 64'(freeze), 64'(0));
    chk("t5_ren_after_rst", 64'(cache_R_en), 64'(0));
    @(posedge clk); #1;
    cache_freeze = 1'b0;
    w0 = wr_seen; r0 = rd_seen;
    do_op(2, 18'h50, 32'h0, s);
    chk("t5_load_stall", 64'(s), 64'(1));
    chk("t5_load_read", 64'(rd_seen - r0), 64'(1));
    idle(4);
    chk("t5_no_writes", 64'(wr_seen - w0), 64'(0));

    // both enables high is a load
    w0 = wr_seen; r0 = rd_seen;
    do_op(3, 18'h20, 32'hDEAD_BEEF, s);
    chk("t6_both_stall", 64'(s), 64'(1));
    chk("t6_both_read", 64'(rd_seen - r0), 64'(1));
    idle(3);
    chk("t6_no_enqueue", 64'(wr_seen - w0), 64'(0));

    // randomized mix with a randomly stalling cache
    cf_random = 1'b1;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      kind = (r < 40) ? 1 : (r < 75) ? 2 : (r < 85) ? 3 : 0;
      a = 18'h80 + 18'($urandom_range(0, 7) * 4) + 18'($urandom_range(0, 3));
      do_op(kind, a, $urandom, s);
    end
    @(posedge clk); #3;
    cf_random = 1'b0;
    cache_freeze = 1'b0;
    @(posedge clk); #1;
    drain();
    chk("loads_left", 64'(lq.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
